// File: rtl/axi4lite_pkg.sv
// Shared types and constants for the Wishbone to AXI4-Lite bridge.
// Holds the bridge FSM encoding and the AXI response codes.
// No logic; imported by the bridge.
package axi4lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        ACK     = 3'd5
    } bridge_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Error responses are the two codes with the top bit set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/wishbone_to_axi4lite.sv
// Wishbone classic slave to AXI4-Lite master bridge, one transfer in flight.
// Latency: 3 cycles stb-sample to ack with a zero-wait slave, +1 per AXI wait cycle.
// Backpressure: holds AXI valids until handshake; Wishbone stb ignored until back in IDLE.
// Optional: define WB_TO_AXI4LITE_ERR_EN to return SLVERR/DECERR as wb_err_o.
module wishbone_to_axi4lite
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // Wishbone slave
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    // AXI4-Lite write
    output logic [ADDR_WIDTH-1:0]   axi_awaddr_o,
    output logic [2:0]              axi_awprot_o,
    output logic                    axi_awvalid_o,
    input  logic                    axi_awready_i,
    output logic [DATA_WIDTH-1:0]   axi_wdata_o,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb_o,
    output logic                    axi_wvalid_o,
    input  logic                    axi_wready_i,
    input  logic [1:0]              axi_bresp_i,
    input  logic                    axi_bvalid_i,
    output logic                    axi_bready_o,
    // AXI4-Lite read
    output logic [ADDR_WIDTH-1:0]   axi_araddr_o,
    output logic [2:0]              axi_arprot_o,
    output logic                    axi_arvalid_o,
    input  logic                    axi_arready_i,
    input  logic [DATA_WIDTH-1:0]   axi_rdata_i,
    input  logic [1:0]              axi_rresp_i,
    input  logic                    axi_rvalid_i,
    output logic                    axi_rready_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    bridge_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [STRB_WIDTH-1:0] sel_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            resp_q;
    logic                  aw_done_q;
    logic                  w_done_q;

    logic req_vld;
    logic aw_hs;
    logic w_hs;

    assign req_vld = wb_cyc_i & wb_stb_i;
    assign aw_hs   = axi_awvalid_o & axi_awready_i;
    assign w_hs    = axi_wvalid_o & axi_wready_i;

    // Request fields come straight from the registered Wishbone cycle, so
    // they cannot move while any valid referring to them is up.
    assign axi_awaddr_o = adr_q;
    assign axi_araddr_o = adr_q;
    assign axi_wdata_o  = dat_q;
    assign axi_wstrb_o  = sel_q;
    assign axi_awprot_o = 3'b000;
    assign axi_arprot_o = 3'b000;
    assign wb_dat_o     = rdata_q;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt     = state;
        axi_awvalid_o = 1'b0;
        axi_wvalid_o  = 1'b0;
        axi_bready_o  = 1'b0;
        axi_arvalid_o = 1'b0;
        axi_rready_o  = 1'b0;
        wb_ack_o      = 1'b0;
        wb_err_o      = 1'b0;
        case (state)
            IDLE: begin
                if (req_vld) begin
                    state_nxt = wb_we_i ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; leave once both are done,
                // counting a handshake completing in this very cycle.
                axi_awvalid_o = ~aw_done_q;
                axi_wvalid_o  = ~w_done_q;
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                axi_bready_o = 1'b1;
                if (axi_bvalid_i) begin
                    state_nxt = ACK;
                end
            end
            RD_REQ: begin
                axi_arvalid_o = 1'b1;
                if (axi_arready_i) begin
                    state_nxt = RD_RESP;
                end
            end
            RD_RESP: begin
                axi_rready_o = 1'b1;
                if (axi_rvalid_i) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
`ifdef WB_TO_AXI4LITE_ERR_EN
                wb_err_o = resp_is_err(resp_q);
                wb_ack_o = ~resp_is_err(resp_q);
`else
                wb_ack_o = 1'b1;
`endif
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifndef WB_TO_AXI4LITE_ERR_EN
    // Response is still latched so both builds share one datapath.
    logic unused_resp;
    assign unused_resp = ^resp_q;
`endif

    // Request capture, per-channel completion flags and response capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (state == IDLE && req_vld) begin
                adr_q     <= wb_adr_i;
                dat_q     <= wb_dat_i;
                sel_q     <= wb_sel_i;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (state == WR_REQ) begin
                if (aw_hs) begin
                    aw_done_q <= 1'b1;
                end
                if (w_hs) begin
                    w_done_q <= 1'b1;
                end
            end
            if (state == WR_RESP && axi_bvalid_i) begin
                resp_q <= axi_bresp_i;
            end
            // Read data is only replaced by the next completed read.
            if (state == RD_RESP && axi_rvalid_i) begin
                rdata_q <= axi_rdata_i;
                resp_q  <= axi_rresp_i;
            end
        end
    end

endmodule

// File: tb/tb_wishbone_to_axi4lite.sv
// Bench for wishbone_to_axi4lite: directed corner cases then random transfers.
// The bench acts as Wishbone master and as an AXI4-Lite slave with per-channel delays.
// Expected handshakes, latency and data come from a transfer-level model.
module tb_wishbone_to_axi4lite;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o, wb_err_o;
    logic [31:0] axi_awaddr_o, axi_wdata_o, axi_araddr_o, axi_rdata_i;
    logic [2:0]  axi_awprot_o, axi_arprot_o;
    logic        axi_awvalid_o, axi_awready_i, axi_wvalid_o, axi_wready_i;
    logic [3:0]  axi_wstrb_o;
    logic [1:0]  axi_bresp_i, axi_rresp_i;
    logic        axi_bvalid_i, axi_bready_o, axi_arvalid_o, axi_arready_i;
    logic        axi_rvalid_i, axi_rready_o;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_rdata = 32'h0;

    always #5 clk_i = ~clk_i;

    wishbone_to_axi4lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .axi_awaddr_o(axi_awaddr_o), .axi_awprot_o(axi_awprot_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
        .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o),
        .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
        .axi_bresp_i(axi_bresp_i), .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o),
        .axi_araddr_o(axi_araddr_o), .axi_arprot_o(axi_arprot_o),
        .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
        .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
        .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic slave_idle();
        axi_awready_i = 1'b0;
        axi_wready_i  = 1'b0;
        axi_bvalid_i  = 1'b0;
        axi_arready_i = 1'b0;
        axi_rvalid_i  = 1'b0;
        axi_bresp_i   = 2'b00;
        axi_rresp_i   = 2'b00;
        axi_rdata_i   = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awvalid"}, axi_awvalid_o, 0);
        check({tag, "_wvalid"},  axi_wvalid_o, 0);
        check({tag, "_bready"},  axi_bready_o, 0);
        check({tag, "_arvalid"}, axi_arvalid_o, 0);
        check({tag, "_rready"},  axi_rready_o, 0);
        check({tag, "_ack"},     wb_ack_o, 0);
        check({tag, "_err"},     wb_err_o, 0);
        check({tag, "_dat"},     wb_dat_o, 0);
        check({tag, "_awaddr"},  axi_awaddr_o, 0);
    endtask

    // One Wishbone transfer against an AXI slave with the given wait counts.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int aw_dly, input int w_dly,
                           input int b_dly, input int ar_dly, input int r_dly,
                           input logic [1:0] resp, input logic [31:0] rdata,
                           input bit drop_cyc, input bit rst_in_resp);
        int  cyc_n, exp_lat;
        int  aw_seen, w_seen, b_seen, ar_seen, r_seen;
        bit  aw_done, w_done, ar_done, resp_done, finished, exp_err;
        aw_seen = 0; w_seen = 0; b_seen = 0; ar_seen = 0; r_seen = 0;
        aw_done = 0; w_done = 0; ar_done = 0; resp_done = 0; finished = 0;
        exp_lat = we ? (((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly + 3) : (ar_dly + r_dly + 3);
`ifdef WB_TO_AXI4LITE_ERR_EN
        exp_err = resp[1];
`else
        exp_err = 1'b0;
`endif
        @(negedge clk_i);
        check("dat_hold", wb_dat_o, last_rdata);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        @(posedge clk_i);
        #1;
        if (drop_cyc) begin
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            wb_adr_i = $urandom; wb_dat_i = $urandom; wb_we_i = ~we;
        end
        cyc_n = 0;
        while (!finished && cyc_n < 64) begin
            @(negedge clk_i);
            cyc_n++;
            check("awvalid", axi_awvalid_o, we && !aw_done);
            check("wvalid",  axi_wvalid_o,  we && !w_done);
            check("bready",  axi_bready_o,  we && aw_done && w_done && !resp_done);
            check("arvalid", axi_arvalid_o, !we && !ar_done);
            check("rready",  axi_rready_o,  !we && ar_done && !resp_done);
            check("ack",     wb_ack_o, resp_done && !exp_err);
            check("err",     wb_err_o, resp_done && exp_err);
            if (rst_in_resp && we && aw_done && w_done) begin
                rst_i = 1'b1;
                #1;
                check_all_zero("rst_mid");
                last_rdata = 32'h0;
                slave_idle();
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
                @(posedge clk_i);
                #1 rst_i = 1'b0;
                return;
            end
            if (resp_done) begin
                check("latency", cyc_n, exp_lat);
                if (!we) begin
                    check("rdata", wb_dat_o, rdata);
                    last_rdata = rdata;
                end
                finished = 1;
                slave_idle();
            end else begin
                slave_idle();
                axi_awready_i = axi_awvalid_o && (aw_seen >= aw_dly);
                axi_wready_i  = axi_wvalid_o  && (w_seen  >= w_dly);
                axi_arready_i = axi_arvalid_o && (ar_seen >= ar_dly);
                if (axi_awvalid_o) aw_seen++;
                if (axi_wvalid_o)  w_seen++;
                if (axi_arvalid_o) ar_seen++;
                if (axi_awready_i) begin
                    check("awaddr", axi_awaddr_o, adr);
                    check("awprot", axi_awprot_o, 0);
                    aw_done = 1;
                end
                if (axi_wready_i) begin
                    check("wdata", axi_wdata_o, dat);
                    check("wstrb", axi_wstrb_o, sel);
                    w_done = 1;
                end
                if (axi_arready_i) begin
                    check("araddr", axi_araddr_o, adr);
                    check("arprot", axi_arprot_o, 0);
                    ar_done = 1;
                end
                if (axi_bready_o) begin
                    axi_bvalid_i = (b_seen >= b_dly);
                    axi_bresp_i  = resp;
                    b_seen++;
                    if (axi_bvalid_i) resp_done = 1;
                end
                if (axi_rready_o) begin
                    axi_rvalid_i = (r_seen >= r_dly);
                    axi_rresp_i  = resp;
                    if (axi_rvalid_i) axi_rdata_i = rdata;
                    r_seen++;
                    if (axi_rvalid_i) resp_done = 1;
                end
            end
        end
        check("completed", finished, 1);
        @(posedge clk_i);
        #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk_i);
        check("ack_single", wb_ack_o, 0);
        check("err_single", wb_err_o, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0;
        slave_idle();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b0;

        // Zero-wait write: AW and W in the same cycle, ack after 3 cycles.
        run_txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        // AW accepted two cycles before W.
        run_txn(1, 32'h20, 32'hCAFEF00D, 4'h3, 0, 2, 0, 0, 0, 2'b00, 0, 0, 0);
        // W accepted before AW, with B wait.
        run_txn(1, 32'h24, 32'h0BADF00D, 4'h5, 3, 1, 2, 0, 0, 2'b00, 0, 0, 0);
        // Read with rvalid four cycles late.
        run_txn(0, 32'h04, 32'h0, 4'hF, 0, 0, 0, 0, 4, 2'b00, 32'h12345678, 0, 0);
        // SLVERR on write response.
        run_txn(1, 32'h30, 32'h55AA55AA, 4'hF, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0);
        // DECERR on read response, with cyc dropped mid-transfer.
        run_txn(0, 32'h34, 32'h0, 4'hF, 0, 0, 0, 2, 1, 2'b11, 32'hA5A5A5A5, 1, 0);
        // Reset while waiting for B, then a normal read.
        run_txn(1, 32'h40, 32'h11111111, 4'hF, 0, 0, 3, 0, 0, 2'b00, 0, 0, 1);
        run_txn(0, 32'h44, 32'h0, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h87654321, 0, 0);

        for (int i = 0; i < 200; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    2'($urandom_range(0, 3)), $urandom,
                    ($urandom_range(0, 7) == 0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wishbone_to_axi4lite.md
WISHBONE_TO_AXI4LITE -- requirements
Module: wishbone_to_axi4lite

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of both buses.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of both buses (multiple of 8).
REQ-003 SHALL have port clk_i, input, 1, single clock for both sides.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have Wishbone slave inputs: wb_cyc_i 1, wb_stb_i 1, wb_we_i 1, wb_adr_i ADDR_WIDTH, wb_sel_i DATA_WIDTH/8, wb_dat_i DATA_WIDTH.
REQ-006 SHALL have Wishbone slave outputs: wb_dat_o DATA_WIDTH, wb_ack_o 1, wb_err_o 1.
REQ-007 SHALL have AXI4-Lite master write ports: axi_awaddr_o ADDR_WIDTH, axi_awprot_o 3, axi_awvalid_o 1, axi_awready_i 1, axi_wdata_o DATA_WIDTH, axi_wstrb_o DATA_WIDTH/8, axi_wvalid_o 1, axi_wready_i 1, axi_bresp_i 2, axi_bvalid_i 1, axi_bready_o 1.
REQ-008 SHALL have AXI4-Lite master read ports: axi_araddr_o ADDR_WIDTH, axi_arprot_o 3, axi_arvalid_o 1, axi_arready_i 1, axi_rdata_i DATA_WIDTH, axi_rresp_i 2, axi_rvalid_i 1, axi_rready_o 1.

Function
REQ-009 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, ACK.
REQ-010 SHALL, in IDLE with wb_cyc_i&wb_stb_i sampled high, register wb_adr_i, wb_dat_i and wb_sel_i, then go to WR_REQ if wb_we_i=1, else RD_REQ.
REQ-011 SHALL in WR_REQ assert axi_awvalid_o and axi_wvalid_o from the first WR_REQ cycle, dropping each independently on its own ready handshake; AW and W may complete in either order or in the same cycle.
REQ-012 SHALL leave WR_REQ for WR_RESP on the cycle both AW and W handshakes have completed.
REQ-013 SHALL assert axi_bready_o only in WR_RESP; on axi_bvalid_i it latches axi_bresp_i and goes to ACK.
REQ-014 SHALL assert axi_arvalid_o in RD_REQ until axi_arready_i, then go to RD_RESP.
REQ-015 SHALL assert axi_rready_o only in RD_RESP; on axi_rvalid_i it registers axi_rdata_i into wb_dat_o, latches axi_rresp_i and goes to ACK.
REQ-016 SHALL in ACK drive wb_ack_o (or wb_err_o, see REQ-024) high for exactly one cycle, then return to IDLE.
REQ-017 SHALL hold wb_dat_o stable from ACK until the next read completes.
REQ-018 SHALL drive axi_awprot_o and axi_arprot_o to 3'b000 and axi_wstrb_o from the registered wb_sel_i.
REQ-019 SHALL keep AXI address/data outputs stable while the corresponding valid is high.
REQ-020 SHALL achieve minimum latency of 3 cycles from the stb-sampled edge to wb_ack_o with a zero-wait AXI slave (both directions); wait cycles on any ready/valid add 1:1.
REQ-021 SHALL ignore wb_cyc_i/wb_stb_i outside IDLE; deassertion of wb_cyc_i mid-transaction does not abort the AXI transfer.

Reset
REQ-022 SHALL, on rst_i high, asynchronously enter IDLE and clear all valid, ready, ack, err outputs, wb_dat_o and internal registers to 0, including mid-transaction.

Configuration
REQ-023 SHALL support macro WB_TO_AXI4LITE_ERR_EN.
REQ-024 SHALL, with WB_TO_AXI4LITE_ERR_EN defined, pulse wb_err_o instead of wb_ack_o when latched resp is SLVERR(2'b10) or DECERR(2'b11); without it, wb_err_o is tied 0 and wb_ack_o always pulses.

Structure
REQ-025 SHALL take FSM state encoding and resp constants (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11) from shared package axi4lite_pkg.
REQ-026 SHALL be a single flat module with no sub-module.

Verification
REQ-027 SHALL cover: write adr 0x10 dat 0xDEADBEEF sel 0xF, zero-wait slave -> AW/W same cycle, wstrb 0xF, wb_ack_o 3 cycles after stb.
REQ-028 SHALL cover: write with awready 2 cycles before wready -> awvalid drops first, wvalid held, single ack after B.
REQ-029 SHALL cover: read adr 0x04, rvalid delayed 4 cycles with rdata 0x12345678 -> wb_dat_o=0x12345678 with ack, latency 7.
REQ-030 SHALL cover: bresp=2'b10 -> wb_err_o pulse with macro, wb_ack_o pulse without.
REQ-031 SHALL cover: rst_i asserted in WR_RESP -> all outputs 0 immediately, next read executes normally.
